// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Each bit is held for CLKS_PER_BIT clocks; tx_out and busy are registered.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] p_data,
    input  logic       data_valid,
    input  logic       par_en,
    input  logic       par_typ,
    output logic       tx_out,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_par_en;
    logic        r_par_bit;
    logic        r_tx;
    logic        r_busy;

    state_t      w_state;
    logic [15:0] w_cnt;
    logic [2:0]  w_idx;
    logic [2:0]  w_idx_inc;
    logic [7:0]  w_shift;
    logic        w_par_en;
    logic        w_par_bit;
    logic        w_tx;
    logic        w_busy;
    logic        w_bit_end;

    assign w_bit_end = (r_cnt == LP_LAST);
    assign w_idx_inc = r_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_shift   <= w_shift;
            r_par_en  <= w_par_en;
            r_par_bit <= w_par_bit;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = w_bit_end ? 16'd0 : r_cnt + 16'd1;
        w_idx     = r_idx;
        w_shift   = r_shift;
        w_par_en  = r_par_en;
        w_par_bit = r_par_bit;
        w_tx      = r_tx;
        w_busy    = r_busy;

        case (r_state)
            S_IDLE: begin
                w_cnt  = 16'd0;
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (data_valid) begin
                    // Parity comes from the byte as latched, so later p_data changes cannot leak in.
                    w_shift   = p_data;
                    w_par_en  = par_en;
                    w_par_bit = (^p_data) ^ par_typ;
                    w_state   = S_START;
                    w_tx      = 1'b0;
                    w_busy    = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state = S_DATA;
                    w_idx   = 3'd0;
                    w_tx    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx != 3'd7) begin
                        w_idx = w_idx_inc;
                        w_tx  = r_shift[w_idx_inc];
                    end else if (r_par_en) begin
                        w_state = S_PARITY;
                        w_tx    = r_par_bit;
                    end else begin
                        w_state = S_STOP;
                        w_tx    = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state = S_STOP;
                    w_tx    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state = S_IDLE;
                    w_tx    = 1'b1;
                    w_busy  = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign tx_out = r_tx;
    assign busy   = r_busy;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer, the counterpart of the receive-side deserializer. It accepts one parallel byte with a valid strobe and shifts it out on a single line, LSB first. Each frame is start bit, 8 data bits, an optional parity bit, then one stop bit. Each bit is held for CLKS_PER_BIT clocks, and the block reports busy while a frame is in flight.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 1..65535
DATA_WIDTH, 8, data bits per frame; fixed at 8 for this block

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk
p_data  input  8  parallel byte to send; sampled only on acceptance
data_valid  input  1  request to send p_data; single-cycle or held
par_en  input  1  1 = parity bit inserted; sampled on acceptance
par_typ  input  1  0 = even parity, 1 = odd parity; sampled on acceptance
tx_out  output  1  serial line; idles high
busy  output  1  high while a frame is being transmitted

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, tx_out=1, busy=0.
  - Bit-period counter=0, bit index=0, shift register=0.
  - Applies mid-frame: the frame is abandoned immediately and the line returns high on that edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, busy=0.
  - If data_valid=1 at an edge, the frame is accepted. p_data, par_en and par_typ are latched, and the parity bit is computed from the latched byte.
  - Even parity: parity bit = XOR of the 8 data bits. Odd parity: its complement.
  - On that same edge: state=START, tx_out=0, busy=1, counter=0.
- Bit timing: every serial bit lasts exactly CLKS_PER_BIT cycles.
  - The counter increments each cycle.
  - On the edge where counter==CLKS_PER_BIT-1, the counter wraps to 0 and the next bit is driven.
  - CLKS_PER_BIT=1 gives one bit per cycle.
- START -> DATA: drive data bit 0, bit index=0.
- DATA:
  - tx_out = latched bit[index].
  - At end of bit with index<7: index+1.
  - At end of bit with index==7: go to PARITY if par_en=1 (drive parity bit), else STOP (drive 1).
- PARITY -> STOP at end of bit; tx_out=1.
- STOP: tx_out=1. At end of bit: state=IDLE, busy=0.
- Latency: tx_out falls on the edge that accepts data_valid, with zero added cycles.
- Frame length:
  - 10*CLKS_PER_BIT cycles of busy=1 without parity.
  - 11*CLKS_PER_BIT cycles with parity.
- data_valid while busy=1 is ignored, including during the final STOP cycle. No queuing, no error flag.
- The minimum gap between frames is one IDLE cycle: the earliest next accept is the edge after busy falls.
- p_data, par_en and par_typ changing mid-frame have no effect on the frame in progress.
- tx_out and busy are registered outputs (glitch-free).

Test Plan:
1. Reset, CLKS_PER_BIT=4, par_en=0, send p_data=0xA5 with a 1-cycle data_valid.
   -> tx_out per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. busy=1 for exactly 40 cycles, then busy=0 and tx_out=1.
2. CLKS_PER_BIT=4, par_en=1, par_typ=0, p_data=0x07.
   -> data bits 1,1,1,0,0,0,0,0, parity bit 1, stop 1. busy=1 for 44 cycles.
   Repeat with par_typ=1: parity bit 0.
3. CLKS_PER_BIT=1, par_en=1, par_typ=1, p_data=0xA5.
   -> 11-cycle frame 0,1,0,1,0,0,1,0,1,1,1 (odd parity=1).
4. Hold data_valid=1 continuously with p_data=0x00 then 0xFF, changing p_data mid-frame.
   -> first frame carries the value latched at accept only. busy drops for exactly 1 cycle between frames. Second frame carries the value present at the second accept.
5. Assert rst_n=0 for one cycle during DATA bit 3 of a frame.
   -> the next edge gives tx_out=1, busy=0. A new data_valid 1 cycle later starts a clean frame from START.
6. Pulse data_valid during STOP of a frame.
   -> ignored; no second frame. tx_out stays 1 after the stop bit.
